// File: rtl/conv_stream_acc_if.sv
// Streaming bus for conv_stream_acc: sample strobe, control pulses,
// coefficient load port and the result/strobe/sum outputs.
interface conv_stream_acc_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = 8
) ();
    localparam int IDX_W = $clog2(TAPS);

    logic              read;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              clr_sum;
    logic              coef_we;
    logic [IDX_W-1:0]  coef_idx;
    logic [COEF_W-1:0] coef_data;
    logic              mode;
    logic              conv_valid;
    logic [OUT_W-1:0]  CONV_OUT;
    logic [OUT_W-1:0]  sumout;

    modport master (
        output read, in_data, flush, clr_sum, coef_we, coef_idx, coef_data, mode,
        input  conv_valid, CONV_OUT, sumout
    );

    modport slave (
        input  read, in_data, flush, clr_sum, coef_we, coef_idx, coef_data, mode,
        output conv_valid, CONV_OUT, sumout
    );
endinterface

// File: rtl/conv_stream_acc.sv
// Streaming convolution engine: TAPS-deep sample window, loadable
// coefficient bank, two-stage multiply/accumulate pipeline with output
// scaling (saturate or wrap) and a running modulo sum of all results.
module conv_stream_acc #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 0,
    parameter int OUT_W  = 8
) (
    input logic CLK,
    input logic RST,
    conv_stream_acc_if.slave bus
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int CNT_W  = $clog2(TAPS + 1);

    logic [DATA_W-1:0] win_q   [TAPS];
    logic [DATA_W-1:0] win_d   [TAPS];
    logic [COEF_W-1:0] coef_q  [TAPS];
    logic [COEF_W-1:0] coef_d  [TAPS];
    logic [PROD_W-1:0] prod_q  [TAPS];
    logic [PROD_W-1:0] prod_d  [TAPS];
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic              tag0_q, tag0_d;
    logic              prod_valid_q, prod_valid_d;
    logic              conv_valid_q, conv_valid_d;
    logic [OUT_W-1:0]  conv_out_q, conv_out_d;
    logic [OUT_W-1:0]  sum_q, sum_d;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  scaled;
    logic              over;

    // Window shift, warm-up fill count and the stage-0 valid tag; flush beats read.
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        tag0_d = 1'b0;
        if (bus.flush) begin
            for (int k = 0; k < TAPS; k++) win_d[k] = '0;
            fill_d = '0;
        end else if (bus.read) begin
            win_d[0] = bus.in_data;
            for (int k = 1; k < TAPS; k++) win_d[k] = win_q[k-1];
            if (fill_q < CNT_W'(TAPS)) fill_d = fill_q + 1'b1;
            tag0_d = (fill_d == CNT_W'(TAPS));
        end
    end

    // Coefficient bank write; an index beyond the bank is ignored.
    always_comb begin
        coef_d = coef_q;
        if (bus.coef_we && (int'(bus.coef_idx) < TAPS)) begin
            coef_d[bus.coef_idx] = bus.coef_data;
        end
    end

    // Stage 1: per-tap products from the current window and coefficients.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = PROD_W'(coef_q[k]) * PROD_W'(win_q[k]);
        end
        prod_valid_d = tag0_q & ~bus.flush;
    end

    // Stage 2: sum, scale, saturate or wrap, and fold the result into the running sum.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(prod_q[k]);
        scaled = acc >> SHIFT;
        over = 1'b0;
        for (int i = OUT_W; i < ACC_W; i++) over = over | scaled[i];
        conv_valid_d = prod_valid_q & ~bus.flush;
        conv_out_d   = conv_out_q;
        if (conv_valid_d) begin
            conv_out_d = (!bus.mode && over) ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
        end
        sum_d = sum_q;
        if (bus.clr_sum) sum_d = '0;
        if (conv_valid_d) sum_d = sum_d + conv_out_d;
    end

    // State registers; reset restores the pass-through coefficient set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < TAPS; k++) begin
                win_q[k]  <= '0;
                coef_q[k] <= (k == 0) ? COEF_W'(1) : '0;
                prod_q[k] <= '0;
            end
            fill_q       <= '0;
            tag0_q       <= 1'b0;
            prod_valid_q <= 1'b0;
            conv_valid_q <= 1'b0;
            conv_out_q   <= '0;
            sum_q        <= '0;
        end else begin
            win_q        <= win_d;
            coef_q       <= coef_d;
            prod_q       <= prod_d;
            fill_q       <= fill_d;
            tag0_q       <= tag0_d;
            prod_valid_q <= prod_valid_d;
            conv_valid_q <= conv_valid_d;
            conv_out_q   <= conv_out_d;
            sum_q        <= sum_d;
        end
    end

    assign bus.conv_valid = conv_valid_q;
    assign bus.CONV_OUT   = conv_out_q;
    assign bus.sumout     = sum_q;
endmodule

// File: tb/tb_conv_stream_acc.sv
// Directed bench for conv_stream_acc (TAPS=4, 8-bit data/coefs/output).
module tb_conv_stream_acc;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int failures = 0;

    conv_stream_acc_if #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(8)) bus ();

    conv_stream_acc #(
        .DATA_W(8), .COEF_W(8), .TAPS(4), .ACC_W(24), .SHIFT(0), .OUT_W(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, then advance past the next rising edge
    task automatic applyStimulus(input logic rd, input logic [7:0] din, input logic fl,
                                 input logic clr, input logic we, input logic [1:0] idx,
                                 input logic [7:0] cd);
        bus.read      = rd;
        bus.in_data   = din;
        bus.flush     = fl;
        bus.clr_sum   = clr;
        bus.coef_we   = we;
        bus.coef_idx  = idx;
        bus.coef_data = cd;
        @(posedge CLK);
        #1;
    endtask

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic sample(input logic [7:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    task automatic writeCoef(input logic [1:0] i, input logic [7:0] v);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, i, v);
    endtask

    task automatic flushAll(input logic clr);
        applyStimulus(1'b0, 8'd0, 1'b1, clr, 1'b0, 2'd0, 8'd0);
    endtask

    // Strobe check; value and sum are checked only on strobe cycles
    task automatic checkCycle(input string tag, input logic v, input logic [7:0] out,
                              input logic [7:0] sum);
        checkOutput({tag, "_valid"}, 32'(bus.conv_valid), 32'(v));
        if (v) begin
            checkOutput({tag, "_out"}, 32'(bus.CONV_OUT), 32'(out));
            checkOutput({tag, "_sum"}, 32'(bus.sumout), 32'(sum));
        end
    endtask

    initial begin
        bus.mode = 1'b0;
        RST = 1'b1;
        idle();
        idle();
        checkOutput("rst_valid", 32'(bus.conv_valid), 32'd0);
        checkOutput("rst_out", 32'(bus.CONV_OUT), 32'd0);
        checkOutput("rst_sum", 32'(bus.sumout), 32'd0);
        RST = 1'b0;

        // Default pass-through coefficients, warm-up with 1..4
        for (int i = 1; i <= 4; i++) begin
            sample(8'(i));
            checkCycle("warm", 1'b0, 8'd0, 8'd0);
        end
        idle();
        checkCycle("pass_t1", 1'b0, 8'd0, 8'd0);
        idle();
        checkCycle("pass", 1'b1, 8'd4, 8'd4);
        idle();
        checkCycle("pass_after", 1'b0, 8'd0, 8'd0);

        // Moving sum of 4, continuous input
        flushAll(1'b1);
        for (int i = 0; i < 4; i++) writeCoef(2'(i), 8'd1);
        for (int i = 1; i <= 5; i++) begin
            sample(8'(10 * i));
            checkCycle("msum_in", 1'b0, 8'd0, 8'd0);
        end
        idle();
        checkCycle("msum_a", 1'b1, 8'd100, 8'd100);
        idle();
        checkCycle("msum_b", 1'b1, 8'd140, 8'd240);
        idle();
        checkCycle("msum_end", 1'b0, 8'd0, 8'd0);

        // Saturate then wrap with acc=260100 (0x3F804)
        flushAll(1'b1);
        for (int i = 0; i < 4; i++) writeCoef(2'(i), 8'd255);
        for (int i = 0; i < 4; i++) sample(8'd255);
        idle();
        idle();
        checkCycle("sat", 1'b1, 8'd255, 8'd255);
        bus.mode = 1'b1;
        sample(8'd255);
        checkCycle("wrap_t0", 1'b0, 8'd0, 8'd0);
        idle();
        checkCycle("wrap_t1", 1'b0, 8'd0, 8'd0);
        idle();
        checkCycle("wrap", 1'b1, 8'd4, 8'd3);
        bus.mode = 1'b0;

        // Stalled input: three idle cycles between samples
        for (int i = 0; i < 4; i++) writeCoef(2'(i), 8'd1);
        flushAll(1'b1);
        for (int i = 0; i < 5; i++) begin
            sample(8'(10 * (i + 1)));
            checkCycle("stall_t0", 1'b0, 8'd0, 8'd0);
            idle();
            checkCycle("stall_t1", 1'b0, 8'd0, 8'd0);
            idle();
            checkCycle("stall_t2", i >= 3, (i == 3) ? 8'd100 : 8'd140,
                       (i == 3) ? 8'd100 : 8'd240);
            idle();
            checkCycle("stall_t3", 1'b0, 8'd0, 8'd0);
        end

        // Flush one cycle after a valid sample, then three more samples
        sample(8'd60);
        flushAll(1'b0);
        checkCycle("flush_f", 1'b0, 8'd0, 8'd0);
        idle();
        checkCycle("flush_a", 1'b0, 8'd0, 8'd0);
        idle();
        checkCycle("flush_b", 1'b0, 8'd0, 8'd0);
        checkOutput("flush_hold_out", 32'(bus.CONV_OUT), 32'd140);
        checkOutput("flush_hold_sum", 32'(bus.sumout), 32'd240);
        for (int i = 1; i <= 3; i++) begin
            sample(8'(i));
            checkCycle("refill", 1'b0, 8'd0, 8'd0);
        end
        idle();
        checkCycle("refill_a", 1'b0, 8'd0, 8'd0);
        idle();
        checkCycle("refill_b", 1'b0, 8'd0, 8'd0);

        // Coefficient write on the accept edge uses the new value
        flushAll(1'b0);
        writeCoef(2'd0, 8'd1);
        for (int i = 1; i < 4; i++) writeCoef(2'(i), 8'd0);
        for (int i = 0; i < 3; i++) sample(8'd0);
        applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 2'd0, 8'd2);
        idle();
        idle();
        checkCycle("cw_same", 1'b1, 8'd10, 8'd250);

        // Coefficient write one edge later uses the old value
        flushAll(1'b0);
        writeCoef(2'd0, 8'd1);
        for (int i = 0; i < 3; i++) sample(8'd0);
        sample(8'd5);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd2);
        idle();
        checkCycle("cw_late", 1'b1, 8'd5, 8'd255);

        // clr_sum coincident with a strobe of 7 while sumout=200
        writeCoef(2'd0, 8'd1);
        applyStimulus(1'b1, 8'd200, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
        idle();
        idle();
        checkCycle("sum200", 1'b1, 8'd200, 8'd200);
        sample(8'd7);
        idle();
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
        checkCycle("clr_add", 1'b1, 8'd7, 8'd7);

        // Reset with two results in flight
        sample(8'd9);
        sample(8'd11);
        RST = 1'b1;
        idle();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput("rst2_valid", 32'(bus.conv_valid), 32'd0);
            checkOutput("rst2_out", 32'(bus.CONV_OUT), 32'd0);
            checkOutput("rst2_sum", 32'(bus.sumout), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_stream_acc.md
Name: conv_stream_acc

Overview:
- Parametrised streaming convolution engine; next generation of the fixed 8-bit conv/sum test block.
- Holds a sliding window of TAPS samples and a loadable coefficient bank, and produces a registered dot product on CONV_OUT with a valid strobe.
- Keeps a running modulo sum of all outputs on sumout.
- Adds over the previous block: configurable widths and taps, output scaling, a saturate/wrap mode, runtime coefficient load, flush and sum clear.

Parameters:
DATA_W, 8, sample width (unsigned)
COEF_W, 8, coefficient width (unsigned)
TAPS, 4, window length, 2..16
ACC_W, 24, internal accumulator width; must be >= DATA_W+COEF_W+clog2(TAPS)
SHIFT, 0, right shift applied to the accumulator before output, 0..ACC_W-OUT_W
OUT_W, 8, width of CONV_OUT and sumout

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
read  in  1  sample strobe; in_data accepted on every rising edge with read=1
in_data  in  DATA_W  input sample
flush  in  1  clear window, fill count and in-flight results
clr_sum  in  1  clear running sum
coef_we  in  1  coefficient write enable
coef_idx  in  clog2(TAPS)  coefficient index
coef_data  in  COEF_W  coefficient value
mode  in  1  0 = saturate output, 1 = wrap (truncate)
conv_valid  out  1  one-cycle strobe; CONV_OUT holds a new result
CONV_OUT  out  OUT_W  scaled convolution result, held between strobes
sumout  out  OUT_W  running sum of results, modulo 2^OUT_W

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST. RST has priority over every other input.
- Reset values:
  - conv_valid=0, CONV_OUT=0, sumout=0.
  - Window and pipeline cleared; fill count=0.
  - Coefficients: c[0]=1, all others 0 (pass-through).
- Window:
  - x[0] is the newest sample.
  - On a read edge: x[k] <= x[k-1], x[0] <= in_data.
  - read=0 holds the window; no backpressure exists.
- Pipeline, all arithmetic unsigned:
  - Edge t: sample accepted.
  - Edge t+1: products p[k]=c[k]*x[k] registered.
  - Edge t+2: acc = sum of p[k] (ACC_W bits), scaled, registered to CONV_OUT; conv_valid high for the following cycle.
  - Latency is exactly 2 cycles. Throughput is one result per cycle under continuous read.
- Warm-up:
  - Fill count increments per accepted sample and saturates at TAPS.
  - A result is tagged valid only if the fill count after its accept edge is >= TAPS.
  - The first TAPS-1 samples after reset or flush produce no strobe.
- Scaling:
  - s = acc >> SHIFT.
  - mode=0: CONV_OUT = min(s, 2^OUT_W-1).
  - mode=1: CONV_OUT = s[OUT_W-1:0].
  - mode is sampled at the t+2 edge.
- Coefficient write:
  - A write on edge e updates c[coef_idx].
  - Products registered on edges > e use the new value; products registered on edge e use the old value.
- Running sum:
  - On a strobing edge: sumout <= sumout + new CONV_OUT, modulo 2^OUT_W.
  - clr_sum alone: sumout <= 0.
  - clr_sum on a strobing edge: sumout <= new CONV_OUT (clear, then add).
- Flush:
  - Clears the window, fill count and both pipeline valid tags, so in-flight results never strobe.
  - CONV_OUT and sumout hold their values.
  - flush together with read: flush wins and the sample is dropped.
- Reset mid-operation: all in-flight results are discarded; no strobe occurs on the cycle after RST deasserts.

Test Plan:
- Reset, default coefficients, TAPS=4: read 1,2,3,4 on consecutive edges -> single conv_valid 2 cycles after the 4th sample, CONV_OUT=4, sumout=4.
- Load c[0..3]=1, feed 10,20,30,40,50 continuously -> strobes on two consecutive cycles with CONV_OUT=100 then 140; sumout=240.
- Coefficients all 255, samples all 255 (acc=260100), mode=0 -> CONV_OUT=255. Repeat with mode=1 -> CONV_OUT=0x04.
- Stall and flush: read gaps of 3 cycles between samples -> each strobe exactly 2 cycles after its sample, values as in the moving-sum case. Pulse flush one cycle after a valid sample -> no strobe for that sample; the next 3 samples produce no strobe.
- Coefficient write on the same edge as sample acceptance (c[0]: 1->2, sample 5, prior window zero) -> CONV_OUT=10. Same write one edge later -> CONV_OUT=5.
- clr_sum coincident with a strobe of value 7 while sumout=200 -> sumout=7. Assert RST with 2 results in flight -> no strobes afterwards, all outputs 0.
